stopwatch_controller: RTL and testbench

Sequencing controller for the stopwatch. It debounces three push-buttons, runs an IDLE/RUNNING/PAUSED state machine and generates a centisecond tick from the 100 MHz clock. It keeps a 4-digit BCD count (SS.cc, 00.00–99.99) and supports a lap/freeze function. It drives the 16-bit `numbers` bus of the seven-segment display driver: digit 0 is numbers[3:0] and is the rightmost display digit.

---
 rtl/stopwatch_pkg.sv | 22 ++
 rtl/button_debouncer.sv | 54 +++++
 rtl/stopwatch_controller.sv | 163 ++++++++++++++++
 tb/tb_stopwatch_controller.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller: FSM encodings, BCD limits
// and default timing parameters.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  localparam int DEFAULT_CLK_FREQ_HZ     = 100_000_000;
  localparam int DEFAULT_TICK_HZ         = 100;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

  // Out-of-range digits fold back to 0 so the display never shows a non-decimal value.
  function automatic logic [3:0] bcd_digit_inc(input logic [3:0] d);
    return (d >= BCD_MAX) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Push-button conditioner: 2-FF synchronizer, stability counter and a one-cycle
// pulse on each accepted rising edge of the debounced level.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic btn_in,
  output logic level,
  output logic rise_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_pulse;
  logic          w_differs;
  logic          w_accept;

  assign w_differs = (r_sync2 != r_level);
  // The pulse is registered alongside the new level so downstream logic sees it
  // on the same cycle the level changes.
  assign w_accept  = w_differs && (r_cnt == CNT_LAST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync1 <= btn_in;
      r_sync2 <= r_sync1;
      if (!w_differs || w_accept) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_accept) begin
        r_level <= r_sync2;
      end
      r_pulse <= w_accept && r_sync2;
    end
  end

  assign level      = r_level;
  assign rise_pulse = r_pulse;

endmodule

// File: rtl/stopwatch_controller.sv
// Stopwatch sequencer: button conditioning, IDLE/RUNNING/PAUSED FSM, centisecond
// prescaler, SS.cc BCD count with lap freeze and the display bus register.
module stopwatch_controller
  import stopwatch_pkg::*;
#(
  parameter int CLK_FREQ_HZ     = DEFAULT_CLK_FREQ_HZ,
  parameter int TICK_HZ         = DEFAULT_TICK_HZ,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        btn_start_stop,
  input  logic        btn_reset,
  input  logic        btn_lap,
  output logic [15:0] numbers,
  output logic        running,
  output logic        lap_active,
  output logic        overflow
);

  localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  logic [2:0]    w_btn_raw;
  logic [2:0]    w_btn_pulse;
  logic [2:0]    w_btn_level_unused;
  logic          w_p_ss;
  logic          w_p_rst;
  logic          w_p_lap;

  state_t        r_state;
  state_t        w_state_next;
  logic [PW-1:0] r_presc;
  logic [15:0]   r_count;
  logic [15:0]   r_lap;
  logic [15:0]   r_numbers;
  logic          r_lap_active;
  logic          r_overflow;
  logic          r_running;

  logic          w_advance;
  logic          w_clear;
  logic          w_lap_toggle;
  logic          w_lap_clear;
  logic          w_tick;
  logic [4:0]    w_carry;
  logic [15:0]   w_count_inc;
  logic [15:0]   w_count_next;

  genvar gi;

  assign w_btn_raw = {btn_lap, btn_reset, btn_start_stop};

  // Only the rising-edge pulses drive the controller; the levels stay internal.
  for (gi = 0; gi < 3; gi++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .btn_in    (w_btn_raw[gi]),
      .level     (w_btn_level_unused[gi]),
      .rise_pulse(w_btn_pulse[gi])
    );
  end

  assign w_p_ss  = w_btn_pulse[0];
  assign w_p_rst = w_btn_pulse[1];
  assign w_p_lap = w_btn_pulse[2];

  always_comb begin
    w_state_next = r_state;
    w_advance    = 1'b0;
    w_clear      = 1'b0;
    w_lap_toggle = 1'b0;
    w_lap_clear  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_p_ss) w_state_next = ST_RUNNING;
      end
      ST_RUNNING: begin
        // The pausing edge freezes time completely, and swallows a coincident lap.
        if (w_p_ss) begin
          w_state_next = ST_PAUSED;
        end else begin
          w_advance    = 1'b1;
          w_lap_toggle = w_p_lap;
        end
      end
      ST_PAUSED: begin
        if (w_p_rst) begin
          w_state_next = ST_IDLE;
          w_clear      = 1'b1;
        end else if (w_p_ss) begin
          w_state_next = ST_RUNNING;
        end
        w_lap_clear = w_p_lap;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_tick = w_advance && (r_presc == PRESC_LAST);

  assign w_carry[0] = w_tick;
  for (gi = 0; gi < 4; gi++) begin : g_bcd
    assign w_count_inc[gi*4 +: 4] = w_carry[gi] ? bcd_digit_inc(r_count[gi*4 +: 4])
                                                : r_count[gi*4 +: 4];
    assign w_carry[gi+1] = w_carry[gi] && (r_count[gi*4 +: 4] >= BCD_MAX);
  end

  assign w_count_next = w_clear ? 16'h0000 : w_count_inc;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= ST_IDLE;
      r_running    <= 1'b0;
      r_presc      <= '0;
      r_count      <= 16'h0000;
      r_lap        <= 16'h0000;
      r_lap_active <= 1'b0;
      r_overflow   <= 1'b0;
      r_numbers    <= 16'h0000;
    end else begin
      r_state   <= w_state_next;
      r_running <= (w_state_next == ST_RUNNING);

      // Held while paused so a resume finishes the interrupted centisecond.
      if (r_state == ST_IDLE || w_clear) begin
        r_presc <= '0;
      end else if (w_advance) begin
        r_presc <= w_tick ? '0 : r_presc + PW'(1);
      end

      r_count <= w_count_next;

      if (w_clear) begin
        r_overflow <= 1'b0;
      end else if (w_carry[4]) begin
        r_overflow <= 1'b1;
      end

      if (w_clear || w_lap_clear) begin
        r_lap_active <= 1'b0;
      end else if (w_lap_toggle) begin
        r_lap_active <= !r_lap_active;
      end

      if (w_lap_toggle && !r_lap_active) begin
        r_lap <= w_count_next;
      end

      r_numbers <= r_lap_active ? r_lap : r_count;
    end
  end

  assign numbers    = r_numbers;
  assign running    = r_running;
  assign lap_active = r_lap_active;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_stopwatch_controller.sv
// Directed bench for stopwatch_controller: a DIV=10 instance for sequencing and a
// DIV=2 instance that reaches the 99.99 wrap within a short run.
module tb_stopwatch_controller;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        b_ss, b_rst, b_lap;
  logic [15:0] numbers;
  logic        running, lap_active, overflow;
  logic        o_ss, o_rst, o_lap;
  logic [15:0] o_numbers;
  logic        o_running, o_lap_active, o_overflow;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  always #5 CLK = ~CLK;

  stopwatch_controller #(
    .CLK_FREQ_HZ(1000), .TICK_HZ(100), .DEBOUNCE_CYCLES(4)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .btn_start_stop(b_ss), .btn_reset(b_rst), .btn_lap(b_lap),
    .numbers(numbers), .running(running), .lap_active(lap_active), .overflow(overflow)
  );

  stopwatch_controller #(
    .CLK_FREQ_HZ(200), .TICK_HZ(100), .DEBOUNCE_CYCLES(4)
  ) dut_ovf (
    .CLK(CLK), .RST_N(RST_N),
    .btn_start_stop(o_ss), .btn_reset(o_rst), .btn_lap(o_lap),
    .numbers(o_numbers), .running(o_running), .lap_active(o_lap_active), .overflow(o_overflow)
  );

  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic goto(input int t);
    while (cyc < t) step();
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  initial begin
    RST_N = 1'b1;
    b_ss = 1'b0; b_rst = 1'b0; b_lap = 1'b0;
    o_ss = 1'b0; o_rst = 1'b0; o_lap = 1'b0;
    #3 RST_N = 1'b0;
    repeat (3) step();
    check("rst_numbers", numbers, 16'h0000);
    check("rst_running", 16'(running), 16'd0);
    check("rst_lap", 16'(lap_active), 16'd0);
    check("rst_ovf", 16'(overflow), 16'd0);
    RST_N = 1'b1;
    repeat (2) step();
    check("post_rst_numbers", numbers, 16'h0000);

    // 3-cycle glitch is shorter than the debounce window
    b_ss = 1'b1;
    repeat (3) step();
    b_ss = 1'b0;
    repeat (20) step();
    check("glitch_running", 16'(running), 16'd0);
    check("glitch_numbers", numbers, 16'h0000);

    // Start: input rises just after edge 0, state changes on edge 7
    cyc = 0;
    b_ss = 1'b1;
    goto(6);    check("start_early", 16'(running), 16'd0);
    goto(7);    check("start_running", 16'(running), 16'd1);
    goto(10);   b_ss = 1'b0;
    goto(107);  check("cnt_0009", numbers, 16'h0009);
    goto(108);  check("carry_0010", numbers, 16'h0010);
    goto(158);  check("cnt_0015", numbers, 16'h0015);

    goto(160);  b_rst = 1'b1;
    goto(168);  check("rst_in_run_ignored", 16'(running), 16'd1);
    goto(170);  b_rst = 1'b0;
    goto(178);  check("rst_in_run_count", numbers, 16'h0017);

    // Pause at 00.23 with prescaler at 4
    goto(235);  b_ss = 1'b1;
    goto(243);  check("pause_running", 16'(running), 16'd0);
                check("pause_value", numbers, 16'h0023);
    goto(245);  b_ss = 1'b0;
    goto(443);  check("pause_hold_200", numbers, 16'h0023);

    // Resume: only 6 more prescaler steps to the next increment
    goto(450);  b_ss = 1'b1;
    goto(457);  check("resume_running", 16'(running), 16'd1);
    goto(460);  b_ss = 1'b0;
    goto(463);  check("resume_before_tick", numbers, 16'h0023);
    goto(464);  check("resume_partial_tick", numbers, 16'h0024);

    goto(500);  b_ss = 1'b1;
    goto(508);  b_ss = 1'b0;
    goto(520);  b_rst = 1'b1;
    goto(527);  check("reset_edge_numbers", numbers, 16'h0028);
                check("reset_edge_running", 16'(running), 16'd0);
    goto(528);  check("reset_numbers", numbers, 16'h0000);
    goto(530);  b_rst = 1'b0;

    // Lap sequence: running from edge 547, count k after edge 547+10k
    goto(540);  b_ss = 1'b1;
    goto(548);  b_ss = 1'b0;
    goto(965);  b_lap = 1'b1;
    goto(973);  b_lap = 1'b0;
                check("lap_set", 16'(lap_active), 16'd1);
                check("lap_value", numbers, 16'h0042);
    goto(1000); check("lap_frozen", numbers, 16'h0042);
    b_lap = 1'b1;
    goto(1008); b_lap = 1'b0;
                check("lap_off", 16'(lap_active), 16'd0);
                check("lap_off_live", numbers, 16'h0046);
    goto(1020); b_lap = 1'b1;
    goto(1028); b_lap = 1'b0;
                check("lap_tick_edge_set", 16'(lap_active), 16'd1);
                check("lap_tick_edge_value", numbers, 16'h0048);
    goto(1040); check("lap_tick_edge_frozen", numbers, 16'h0048);

    b_ss = 1'b1;
    goto(1048); b_ss = 1'b0;
                check("pause_lap_running", 16'(running), 16'd0);
                check("pause_lap_kept", 16'(lap_active), 16'd1);
    goto(1060); b_lap = 1'b1;
    goto(1068); b_lap = 1'b0;
                check("lap_in_pause", 16'(lap_active), 16'd0);
                check("lap_in_pause_live", numbers, 16'h0049);

    // Paused with prescaler at DIV-1: the first running edge ticks
    goto(1080); b_ss = 1'b1;
    goto(1087); check("resume2_running", 16'(running), 16'd1);
    goto(1088); b_ss = 1'b0;
                check("resume2_hold", numbers, 16'h0049);
    goto(1089); check("resume2_tick", numbers, 16'h0050);

    goto(1100); b_ss = 1'b1; b_lap = 1'b1;
    goto(1108); b_ss = 1'b0; b_lap = 1'b0;
                check("ss_lap_running", 16'(running), 16'd0);
                check("ss_lap_lap", 16'(lap_active), 16'd0);
                check("ss_lap_numbers", numbers, 16'h0051);

    goto(1120); b_ss = 1'b1; b_rst = 1'b1;
    goto(1128); b_ss = 1'b0; b_rst = 1'b0;
                check("rst_ss_running", 16'(running), 16'd0);
                check("rst_ss_numbers", numbers, 16'h0000);
    goto(1140); check("rst_ss_stay_idle", 16'(running), 16'd0);

    // Asynchronous reset in the middle of a count
    goto(1150); b_ss = 1'b1;
    goto(1158); b_ss = 1'b0;
    goto(1200); check("pre_async_numbers", numbers, 16'h0004);
                check("pre_async_running", 16'(running), 16'd1);
    RST_N = 1'b0;
    #1;
    check("async_numbers", numbers, 16'h0000);
    check("async_running", 16'(running), 16'd0);
    step();
    step();
    RST_N = 1'b1;
    cyc = 0;
    b_ss = 1'b1;
    goto(6);    check("post_async_early", 16'(running), 16'd0);
    goto(7);    check("post_async_start", 16'(running), 16'd1);
    goto(8);    b_ss = 1'b0;

    // Overflow instance, DIV=2: count k after edge 7+2k
    cyc = 0;
    o_ss = 1'b1;
    goto(8);     o_ss = 1'b0;
    goto(20004); check("ovf_9998", o_numbers, 16'h9998);
                 check("ovf_flag_pre", 16'(o_overflow), 16'd0);
    goto(20006); check("ovf_9999", o_numbers, 16'h9999);
                 check("ovf_flag_9999", 16'(o_overflow), 16'd0);
    goto(20007); check("ovf_flag_set", 16'(o_overflow), 16'd1);
    goto(20008); check("ovf_wrap", o_numbers, 16'h0000);
    goto(20010); o_ss = 1'b1;
    goto(20018); o_ss = 1'b0;
                 check("ovf_pause_running", 16'(o_running), 16'd0);
                 check("ovf_pause_flag", 16'(o_overflow), 16'd1);
    goto(20030); o_rst = 1'b1;
    goto(20038); o_rst = 1'b0;
                 check("ovf_reset_flag", 16'(o_overflow), 16'd0);
                 check("ovf_reset_numbers", o_numbers, 16'h0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
